// File: rtl/core_pkg.sv
// Shared constants and types for the single-cycle core: the NOP encoding, the opcodes
// shared with the decoder, the fetch FSM states and a loader word-assembly helper.
package core_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {
    StLoad = 1'b0,
    StRun  = 1'b1
  } fetch_state_e;

  // Merge the byte arriving in lane `lane` with the lanes already collected; higher lanes are
  // zero, so a short final word comes out zero-filled.
  function automatic logic [31:0] assemble_word(input logic [23:0] lanes,
                                                input logic [7:0]  data,
                                                input logic [1:0]  lane);
    logic [31:0] word;
    case (lane)
      2'd0:    word = {24'h00_0000, data};
      2'd1:    word = {16'h0000, data, lanes[7:0]};
      2'd2:    word = {8'h00, data, lanes[15:0]};
      default: word = {data, lanes[23:0]};
    endcase
    return word;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction storage: one synchronous write port for the boot loader and one
// asynchronous read port feeding the fetch path. Contents are not reset.
module instr_mem #(
  parameter int unsigned IMEM_DEPTH = 64,
  localparam int unsigned AW = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [IMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: byte-serial boot loader filling instruction memory, then a free-running
// PC that fetches one instruction per cycle and follows taken branches.
module instr_fetch
  import core_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        load_err,
  input  logic        PCSrc,
  input  logic [31:0] ImmExt,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] Instr,
  output logic        run
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(IMEM_DEPTH);

  fetch_state_e state_q, state_d;
  logic [1:0]   byte_cnt_q, byte_cnt_d;
  logic [AW:0]  word_cnt_q, word_cnt_d;
  logic [23:0]  asm_q, asm_d;
  logic         load_err_q, load_err_d;
  logic [31:0]  pc_q, pc_d;

  logic        accept;
  logic        write_try;
  logic        mem_full;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  assign accept    = load_valid && (state_q == StLoad);
  assign write_try = accept && ((byte_cnt_q == 2'd3) || load_last);
  assign mem_full  = (word_cnt_q == FullCnt);
  assign mem_wdata = assemble_word(asm_q, load_byte, byte_cnt_q);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    load_err_d = load_err_q;
    pc_d       = pc_q;
    mem_we     = 1'b0;

    unique case (state_q)
      StLoad: begin
        pc_d = RESET_PC;
        if (accept) begin
          if (write_try) begin
            // Once the memory is full, writes are dropped but bytes keep flowing.
            mem_we     = !mem_full;
            load_err_d = load_err_q | mem_full;
            byte_cnt_d = 2'd0;
            if (!mem_full) begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end else begin
            asm_d[{byte_cnt_q, 3'b000} +: 8] = load_byte;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
          if (load_last) begin
            state_d    = StRun;
            byte_cnt_d = 2'd0;
            word_cnt_d = '0;
          end
        end
      end
      StRun: begin
        pc_d = PCSrc ? (pc_q + ImmExt) : (pc_q + 32'd4);
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StLoad;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= '0;
      asm_q      <= 24'h00_0000;
      load_err_q <= 1'b0;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      load_err_q <= load_err_d;
      pc_q       <= pc_d;
    end
  end

  instr_mem #(
    .IMEM_DEPTH(IMEM_DEPTH)
  ) u_instr_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(word_cnt_q[AW-1:0]),
    .wdata(mem_wdata),
    .raddr(pc_q[AW+1:2]),
    .rdata(mem_rdata)
  );

  assign load_ready = (state_q == StLoad);
  assign run        = (state_q == StRun);
  assign load_err   = load_err_q;
  assign PC         = pc_q;
  assign PCPlus4    = pc_q + 32'd4;
  // Decoder sees a harmless NOP until the image is in place.
  assign Instr      = run ? mem_rdata : NOP_INSTR;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 4-word memory: loader, fetch/branch table,
// aliasing, wrap, async reset and overflow corner cases.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [7:0]  load_byte = 8'h00;
  logic        load_last = 1'b0;
  logic        load_err;
  logic        PCSrc = 1'b0;
  logic [31:0] ImmExt = 32'h0;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] Instr;
  logic        run;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W0 = 32'h1122_3344;
  localparam logic [31:0] W1 = 32'h5566_7788;
  localparam logic [31:0] W2 = 32'h99AA_BBCC;
  localparam logic [31:0] W3 = 32'hDDEE_FF00;

  instr_fetch #(
    .IMEM_DEPTH(4),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_byte (load_byte),
    .load_last (load_last),
    .load_err  (load_err),
    .PCSrc     (PCSrc),
    .ImmExt    (ImmExt),
    .PC        (PC),
    .PCPlus4   (PCPlus4),
    .Instr     (Instr),
    .run       (run)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        src;
    logic [31:0] imm;
    logic        lv;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc4;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Present one loader byte for one cycle; returns at the following negedge.
  task automatic put(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] w, input logic last);
    put(w[7:0], 1'b0);
    put(w[15:8], 1'b0);
    put(w[23:16], 1'b0);
    put(w[31:24], last);
  endtask

  task automatic step(input logic src, input logic [31:0] imm);
    PCSrc  = src;
    ImmExt = imm;
    @(negedge clk);
    PCSrc  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //            src   imm            lv    exp_pc         exp_pc4        exp_instr
    vecs[0]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0000, 32'h0000_0004, W0};
    vecs[1]  = '{1'b0, 32'h0,         1'b0, 32'h0000_0004, 32'h0000_0008, W1};
    vecs[2]  = '{1'b1, 32'hFFFF_FFF8, 1'b1, 32'h0000_0008, 32'h0000_000C, W2};
    vecs[3]  = '{1'b1, 32'h0000_000C, 1'b0, 32'h0000_0000, 32'h0000_0004, W0};
    vecs[4]  = '{1'b0, 32'h0,         1'b1, 32'h0000_000C, 32'h0000_0010, W3};
    vecs[5]  = '{1'b1, 32'hFFFF_FFF0, 1'b0, 32'h0000_0010, 32'h0000_0014, W0};
    vecs[6]  = '{1'b1, 32'h0000_0007, 1'b0, 32'h0000_0000, 32'h0000_0004, W0};
    vecs[7]  = '{1'b1, 32'hFFFF_FFF0, 1'b1, 32'h0000_0007, 32'h0000_000B, W1};
    vecs[8]  = '{1'b0, 32'h0,         1'b0, 32'hFFFF_FFF7, 32'hFFFF_FFFB, W1};
    vecs[9]  = '{1'b0, 32'h0,         1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, W2};
    vecs[10] = '{1'b0, 32'h0,         1'b0, 32'hFFFF_FFFF, 32'h0000_0003, W3};
    vecs[11] = '{1'b0, 32'h0,         1'b0, 32'h0000_0003, 32'h0000_0007, W0};

    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_pc", PC, 32'h0);
    check("rst_pc4", PCPlus4, 32'h4);
    check("rst_instr", Instr, NOP);
    check("rst_run", {31'b0, run}, 32'd0);
    check("rst_ready", {31'b0, load_ready}, 32'd1);
    check("rst_err", {31'b0, load_err}, 32'd0);

    // Two-word load; a branch during the switching cycle must be ignored
    put_word(32'h0050_0013, 1'b0);
    check("load_ready_mid", {31'b0, load_ready}, 32'd1);
    check("load_instr_nop", Instr, NOP);
    check("load_pc_hold", PC, 32'h0);
    PCSrc  = 1'b1;
    ImmExt = 32'h0000_0100;
    put_word(32'h0010_0093, 1'b1);
    PCSrc  = 1'b0;
    check("t1_run", {31'b0, run}, 32'd1);
    check("t1_ready", {31'b0, load_ready}, 32'd0);
    check("t1_pc0", PC, 32'h0);
    check("t1_instr0", Instr, 32'h0050_0013);
    step(1'b0, 32'h0);
    check("t1_pc4", PC, 32'h4);
    check("t1_instr1", Instr, 32'h0010_0093);

    // Async reset mid-run
    #2 rst = 1'b1;
    #1;
    check("arst_run", {31'b0, run}, 32'd0);
    check("arst_instr", Instr, NOP);
    check("arst_pc", PC, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Full 4-word image, then the fetch/branch table with stray load_valid in RUN
    put_word(W0, 1'b0);
    put_word(W1, 1'b0);
    put_word(W2, 1'b0);
    put_word(W3, 1'b1);
    check("t3_err", {31'b0, load_err}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("v%0d_pc", i), PC, vecs[i].exp_pc);
      check($sformatf("v%0d_pc4", i), PCPlus4, vecs[i].exp_pc4);
      check($sformatf("v%0d_instr", i), Instr, vecs[i].exp_instr);
      check($sformatf("v%0d_ready", i), {31'b0, load_ready}, 32'd0);
      load_valid = vecs[i].lv;
      load_byte  = 8'hEE;
      load_last  = vecs[i].lv;
      step(vecs[i].src, vecs[i].imm);
      load_valid = 1'b0;
      load_last  = 1'b0;
    end

    // Partial last word: zero-filled, other words untouched
    do_reset();
    put(8'hAA, 1'b0);
    put(8'hBB, 1'b0);
    put(8'hCC, 1'b1);
    check("t2_run", {31'b0, run}, 32'd1);
    check("t2_instr0", Instr, 32'h00CC_BBAA);
    step(1'b0, 32'h0);
    check("t2_instr1", Instr, W1);

    // Async reset mid-load after 6 bytes, then a fresh load restarts at word 0
    do_reset();
    put_word(32'h0403_0201, 1'b0);
    put(8'h05, 1'b0);
    put(8'h06, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t5_ready", {31'b0, load_ready}, 32'd1);
    check("t5_run", {31'b0, run}, 32'd0);
    check("t5_instr", Instr, NOP);
    @(negedge clk);
    rst = 1'b0;
    put_word(32'hD4C3_B2A1, 1'b1);
    check("t5_instr0", Instr, 32'hD4C3_B2A1);
    step(1'b0, 32'h0);
    check("t5_instr1", Instr, W1);

    // Overflow: 20 bytes into 4 words
    do_reset();
    for (int i = 1; i <= 19; i++) begin
      put(8'(i), 1'b0);
      if (i == 16) check("ovf_err16", {31'b0, load_err}, 32'd0);
    end
    check("ovf_err19", {31'b0, load_err}, 32'd0);
    check("ovf_ready19", {31'b0, load_ready}, 32'd1);
    put(8'd20, 1'b1);
    check("ovf_err20", {31'b0, load_err}, 32'd1);
    check("ovf_run", {31'b0, run}, 32'd1);
    check("ovf_w0", Instr, 32'h0403_0201);
    step(1'b0, 32'h0);
    check("ovf_w1", Instr, 32'h0807_0605);
    step(1'b0, 32'h0);
    check("ovf_w2", Instr, 32'h0C0B_0A09);
    step(1'b0, 32'h0);
    check("ovf_w3", Instr, 32'h100F_0E0D);
    check("ovf_err_sticky", {31'b0, load_err}, 32'd1);
    do_reset();
    check("ovf_err_clr", {31'b0, load_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
